ac_motor_dir_sequencer: RTL and testbench



---
 rtl/ac_motor_dir_sequencer.sv | 150 +++++++++++++++
 tb/tb_ac_motor_dir_sequencer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ac_motor_dir_sequencer.sv
// ac_motor_dir_sequencer: turns raw CW/CCW requests into clean generator drive
// with dead time on stop/reversal and lock supervision with timeout.
//
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   cmd_cw, cmd_ccw     - direction requests (level); both high = no command
//   lock                - lock indication from the triangle generator
//   cw_in, ccw_in       - registered drive to the triangle generator
//   busy                - high in START and STOP
//   fault               - high in FAULT
//   state               - IDLE=0 START=1 RUN=2 STOP=3 FAULT=4
//
// Parameters: DEAD_TIME (1..65535), LOCK_TIMEOUT (1..65535).
// Macro AC_MOTOR_SEQ_RELOCK_EN: lock loss in RUN returns to START to relock
// instead of faulting immediately.

module ac_motor_dir_sequencer #(
    parameter int unsigned DEAD_TIME    = 1000,
    parameter int unsigned LOCK_TIMEOUT = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_cw,
    input  logic       cmd_ccw,
    input  logic       lock,
    output logic       cw_in,
    output logic       ccw_in,
    output logic       busy,
    output logic       fault,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_RUN   = 3'd2,
        ST_STOP  = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    // dir encoding: 0 = CW, 1 = CCW
    localparam logic DIR_CW  = 1'b0;
    localparam logic DIR_CCW = 1'b1;

    localparam logic [15:0] DEAD_LAST = 16'(DEAD_TIME - 1);
    localparam logic [15:0] LOCK_LAST = 16'(LOCK_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic        dir_q, dir_d;
    logic        cw_in_q, cw_in_d;
    logic        ccw_in_q, ccw_in_d;

    logic cmd_valid;
    logic cmd_match;

    assign cmd_valid = cmd_cw ^ cmd_ccw;
    // With exactly one request high, cmd_ccw alone names the direction.
    assign cmd_match = cmd_valid && (cmd_ccw == dir_q);

    // State register and all other flops
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            timer_q  <= 16'd0;
            dir_q    <= DIR_CW;
            cw_in_q  <= 1'b0;
            ccw_in_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            dir_q    <= dir_d;
            cw_in_q  <= cw_in_d;
            ccw_in_q <= ccw_in_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_d = ST_START;
                    dir_d   = cmd_ccw ? DIR_CCW : DIR_CW;
                end
            end
            ST_START: begin
                if (!cmd_match) begin
                    state_d = ST_STOP;
                end else if (lock) begin
                    state_d = ST_RUN;
                end else if (timer_q == LOCK_LAST) begin
                    state_d = ST_FAULT;
                end
            end
            ST_RUN: begin
                if (!cmd_match) begin
                    state_d = ST_STOP;
                end else if (!lock) begin
`ifdef AC_MOTOR_SEQ_RELOCK_EN
                    state_d = ST_START;
`else
                    state_d = ST_FAULT;
`endif
                end
            end
            ST_STOP: begin
                if (timer_q == DEAD_LAST) begin
                    state_d = ST_IDLE;
                end
            end
            ST_FAULT: begin
                if (!cmd_cw && !cmd_ccw) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output / datapath logic: drives follow the next state so that the
    // registered drive changes on the same edge as the state.
    always_comb begin
        timer_d  = timer_q;
        cw_in_d  = 1'b0;
        ccw_in_d = 1'b0;

        if (state_d != state_q) begin
            timer_d = 16'd0;
        end else if (state_q == ST_START || state_q == ST_STOP) begin
            timer_d = timer_q + 16'd1;
        end

        if (state_d == ST_START || state_d == ST_RUN) begin
            cw_in_d  = (dir_d == DIR_CW);
            ccw_in_d = (dir_d == DIR_CCW);
        end
    end

    assign cw_in  = cw_in_q;
    assign ccw_in = ccw_in_q;
    assign busy   = (state_q == ST_START) || (state_q == ST_STOP);
    assign fault  = (state_q == ST_FAULT);
    assign state  = state_q;

endmodule

// File: tb/tb_ac_motor_dir_sequencer.sv
// tb_ac_motor_dir_sequencer: directed plan steps followed by random stimulus,
// every cycle compared against an elapsed-time reference model.

module tb_ac_motor_dir_sequencer;

    localparam int DT = 4;
    localparam int LT = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_cw = 1'b0;
    logic       cmd_ccw = 1'b0;
    logic       lock = 1'b0;
    logic       cw_in, ccw_in, busy, fault;
    logic [2:0] state;

    int errors = 0;
    int checks = 0;

    // Reference model: phase number, direction, edge of phase entry
    int m_phase = 0;
    bit m_dir   = 1'b0;
    int m_entry = 0;
    int edge_no = 0;

    ac_motor_dir_sequencer #(
        .DEAD_TIME   (DT),
        .LOCK_TIMEOUT(LT)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .cmd_cw (cmd_cw),
        .cmd_ccw(cmd_ccw),
        .lock   (lock),
        .cw_in  (cw_in),
        .ccw_in (ccw_in),
        .busy   (busy),
        .fault  (fault),
        .state  (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance the model by one edge using the inputs seen at that edge.
    task automatic model_edge();
        int  nxt;
        int  elapsed;
        bit  valid;
        bit  same;
        edge_no++;
        if (reset) begin
            m_phase = 0;
            m_dir   = 1'b0;
            m_entry = edge_no;
            return;
        end
        elapsed = edge_no - m_entry;
        valid   = cmd_cw ^ cmd_ccw;
        same    = valid && (cmd_ccw == m_dir);
        nxt     = m_phase;
        case (m_phase)
            0: if (valid) begin
                nxt   = 1;
                m_dir = cmd_ccw;
            end
            1: begin
                if (!same) nxt = 3;
                else if (lock) nxt = 2;
                else if (elapsed == LT) nxt = 4;
            end
            2: begin
                if (!same) nxt = 3;
`ifdef AC_MOTOR_SEQ_RELOCK_EN
                else if (!lock) nxt = 1;
`else
                else if (!lock) nxt = 4;
`endif
            end
            3: if (elapsed == DT) nxt = 0;
            default: if (!cmd_cw && !cmd_ccw) nxt = 0;
        endcase
        if (nxt != m_phase) m_entry = edge_no;
        m_phase = nxt;
    endtask

    function automatic logic [6:0] model_out();
        bit drv;
        drv = (m_phase == 1) || (m_phase == 2);
        return {3'(m_phase), drv && !m_dir, drv && m_dir,
                (m_phase == 1) || (m_phase == 3), m_phase == 4};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("model", {25'd0, state, cw_in, ccw_in, busy, fault},
            {25'd0, model_out()});
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_drv", {30'd0, cw_in, ccw_in}, 32'd0);
        chk("rst_flags", {30'd0, busy, fault}, 32'd0);
        reset = 1'b0;
        tick();

        // Start CW, lock 5 cycles later
        cmd_cw = 1'b1;
        tick();
        chk("start_cw", 32'(cw_in), 32'd1);
        chk("start_state", 32'(state), 32'd1);
        for (int i = 0; i < 4; i++) tick();
        lock = 1'b1;
        tick();
        chk("run_state", 32'(state), 32'd2);
        chk("run_ccw", 32'(ccw_in), 32'd0);

        // Reversal to CCW, lock dropped so the new START times out
        cmd_cw  = 1'b0;
        cmd_ccw = 1'b1;
        for (int i = 0; i < DT; i++) begin
            tick();
            chk("rev_stop", {29'd0, state, cw_in | ccw_in}, {29'd0, 3'd3, 1'b0});
        end
        lock = 1'b0;
        tick();
        chk("rev_idle", 32'(state), 32'd0);
        tick();
        chk("rev_start", {29'd0, state, ccw_in}, {29'd0, 3'd1, 1'b1});

        // Lock timeout
        for (int i = 1; i < LT; i++) tick();
        chk("pre_tmo", 32'(state), 32'd1);
        tick();
        chk("tmo_state", 32'(state), 32'd4);
        chk("tmo_flags", {29'd0, fault, busy, cw_in, ccw_in}, 32'd8);
        tick();
        chk("fault_hold", 32'(state), 32'd4);
        cmd_ccw = 1'b0;
        tick();
        chk("fault_exit", 32'(state), 32'd0);

        // Invalid command
        cmd_cw  = 1'b1;
        cmd_ccw = 1'b1;
        tick();
        tick();
        chk("inv_idle", {29'd0, state, cw_in | ccw_in}, 32'd0);
        cmd_ccw = 1'b0;
        lock    = 1'b1;
        tick();
        tick();
        chk("inv_run", 32'(state), 32'd2);
        cmd_ccw = 1'b1;
        tick();
        chk("inv_stop", 32'(state), 32'd3);
        cmd_cw  = 1'b0;
        cmd_ccw = 1'b0;
        for (int i = 0; i < DT; i++) tick();
        chk("inv_back", 32'(state), 32'd0);

        // Lock loss in RUN
        cmd_cw = 1'b1;
        tick();
        tick();
        lock = 1'b0;
        tick();
`ifdef AC_MOTOR_SEQ_RELOCK_EN
        chk("loss_relock", {29'd0, state, cw_in}, {29'd0, 3'd1, 1'b1});
        for (int i = 0; i < 3; i++) tick();
        lock = 1'b1;
        tick();
        chk("relock_run", 32'(state), 32'd2);
`else
        chk("loss_fault", {29'd0, state, cw_in}, {29'd0, 3'd4, 1'b0});
`endif

        // Reset mid-RUN
        reset = 1'b1;
        tick();
        reset = 1'b0;
        cmd_cw = 1'b0;
        tick();
        cmd_cw = 1'b1;
        lock   = 1'b1;
        tick();
        tick();
        chk("pre_rst_run", 32'(state), 32'd2);
        reset = 1'b1;
        tick();
        chk("rst_run", {25'd0, state, cw_in, ccw_in, busy, fault}, 32'd0);
        reset = 1'b0;
        tick();
        chk("rst_run_new", {29'd0, state, cw_in}, {29'd0, 3'd1, 1'b1});

        // Reset mid-STOP
        cmd_cw = 1'b0;
        tick();
        tick();
        chk("pre_rst_stop", 32'(state), 32'd3);
        reset   = 1'b1;
        cmd_ccw = 1'b1;
        tick();
        chk("rst_stop", {25'd0, state, cw_in, ccw_in, busy, fault}, 32'd0);
        reset = 1'b0;
        tick();
        chk("rst_stop_new", {29'd0, state, ccw_in}, {29'd0, 3'd1, 1'b1});

        // Random phase
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 11) == 0) begin
                int c;
                c = int'($urandom_range(0, 3));
                cmd_cw  = c[0];
                cmd_ccw = c[1];
            end
            if ($urandom_range(0, 9) == 0) lock = ($urandom_range(0, 3) != 0);
            reset = ($urandom_range(0, 399) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
